// File: rtl/desarme_pkg.sv
// desarme_pkg: shared types and helpers for the defuse controller.
// Holds the digit width, the controller state encoding and the helper
// that extracts one digit from the packed secret word.
package desarme_pkg;

    localparam int DIGIT_W           = 4;
    localparam int SECRET_MAX_DIGITS = 16;
    localparam int SECRET_MAX_W      = DIGIT_W * SECRET_MAX_DIGITS;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        DEFUSED,
        EXPLODED
    } state_t;

    // Digit k of a packed code word; digit 0 is the first one keyed in.
    function automatic logic [DIGIT_W-1:0] secret_digit(
        input logic [SECRET_MAX_W-1:0] vec,
        input int                      k
    );
        return vec[k*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/comparador_4_bits.sv
// comparador_4_bits: digit equality comparator shared by the defuse path.
// s is high only while enabled and both digits are equal.
module comparador_4_bits
    import desarme_pkg::*;
(
    input  logic               enable,
    input  logic [DIGIT_W-1:0] q1,
    input  logic [DIGIT_W-1:0] q2,
    output logic               s
);

    assign s = enable & (q1 == q2);

endmodule

// File: rtl/controlador_desarme.sv
// controlador_desarme: keypad defuse sequencer.
// Collects CODE_LEN digits, compares them one per cycle against the secret,
// tracks remaining attempts and a 1 Hz countdown.
// Optional feature macro: TIME_PENALTY_EN (wrong attempts also cost PENALTY
// seconds, saturating at zero).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not armed, waiting for arm
// ENTRY    | collecting keypad digits into the buffer
// CHECK    | comparing buffered digit idx against the secret, one per cycle
// DEFUSED  | correct code entered in time (terminal until re-armed)
// EXPLODED | out of attempts or out of time (terminal until re-armed)
module controlador_desarme
    import desarme_pkg::*;
#(
    parameter  int CODE_LEN   = 4,
    parameter  int MAX_TRIES  = 3,
    parameter  int START_TIME = 60,
    parameter  int PENALTY    = 10,
    localparam int TW         = $clog2(START_TIME + 1),
    localparam int RW         = $clog2(MAX_TRIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arm,
    input  logic                        tick_1hz,
    input  logic                        digit_valid,
    input  logic [DIGIT_W-1:0]          digit,
    input  logic [DIGIT_W*CODE_LEN-1:0] secret,
    output logic                        armed,
    output logic                        busy,
    output logic                        defused,
    output logic                        exploded,
    output logic [TW-1:0]               time_left,
    output logic [RW-1:0]               tries_left
);

    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);

`ifdef TIME_PENALTY_EN
    localparam int unsigned PEN_EFF = PENALTY;
`else
    // Penalty weight is zero when wrong attempts only cost a try.
    localparam int unsigned PEN_EFF = PENALTY * 0;
`endif

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [DIGIT_W-1:0] dig_buf_q [CODE_LEN];
    logic               mismatch_q;
    logic [TW-1:0]      time_q;
    logic [RW-1:0]      tries_q;

    logic               last_idx;
    logic               cmp_en;
    logic [DIGIT_W-1:0] cmp_q1;
    logic [DIGIT_W-1:0] cmp_q2;
    logic               cmp_s;
    logic               mismatch_d;
    logic               wrong;
    logic [31:0]        sub;
    logic [TW-1:0]      time_d;
    logic               expire;

    comparador_4_bits u_cmp (
        .enable (cmp_en),
        .q1     (cmp_q1),
        .q2     (cmp_q2),
        .s      (cmp_s)
    );

    // Digit mux for the comparator, attempt verdict and countdown arithmetic.
    always_comb begin
        last_idx   = (idx_q == LAST_IDX);
        cmp_en     = (state_q == CHECK);
        cmp_q1     = dig_buf_q[idx_q];
        cmp_q2     = secret_digit(SECRET_MAX_W'(secret), int'(idx_q));
        mismatch_d = mismatch_q | ~cmp_s;
        wrong      = cmp_en & last_idx & mismatch_d;
        sub        = {31'b0, tick_1hz} + (wrong ? 32'(PEN_EFF) : 32'd0);
        time_d     = (32'(time_q) > sub) ? TW'(32'(time_q) - sub) : '0;
        expire     = (time_d == '0);
    end

    // Controller FSM; expiry overrides every other outcome of the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            time_q     <= '0;
            tries_q    <= '0;
            for (int k = 0; k < CODE_LEN; k++) begin
                dig_buf_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, DEFUSED, EXPLODED: begin
                    if (arm) begin
                        state_q <= ENTRY;
                        time_q  <= TW'(START_TIME);
                        tries_q <= RW'(MAX_TRIES);
                        idx_q   <= '0;
                    end
                end
                ENTRY: begin
                    time_q <= time_d;
                    if (digit_valid) begin
                        dig_buf_q[idx_q] <= digit;
                        if (last_idx) begin
                            state_q    <= CHECK;
                            idx_q      <= '0;
                            mismatch_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    if (expire) begin
                        state_q <= EXPLODED;
                    end
                end
                CHECK: begin
                    time_q     <= time_d;
                    mismatch_q <= mismatch_d;
                    if (last_idx) begin
                        idx_q <= '0;
                        if (mismatch_d) begin
                            tries_q <= tries_q - 1'b1;
                            state_q <= (tries_q == RW'(1)) ? EXPLODED : ENTRY;
                        end else begin
                            state_q <= DEFUSED;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                    if (expire) begin
                        state_q <= EXPLODED;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign armed      = (state_q == ENTRY) || (state_q == CHECK);
    assign busy       = (state_q == CHECK);
    assign defused    = (state_q == DEFUSED);
    assign exploded   = (state_q == EXPLODED);
    assign time_left  = time_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_controlador_desarme.sv
// tb_controlador_desarme: scoreboard bench for the defuse controller.
// Each driven cycle pushes the reference model's expected outputs; a monitor
// pops and compares them on the following falling edge.
module tb_controlador_desarme;

    localparam int CODE_LEN   = 4;
    localparam int MAX_TRIES  = 3;
    localparam int START_TIME = 60;
    localparam int PENALTY    = 10;
    localparam int TW         = $clog2(START_TIME + 1);
    localparam int RW         = $clog2(MAX_TRIES + 1);
`ifdef TIME_PENALTY_EN
    localparam int PEN = PENALTY;
`else
    localparam int PEN = 0;
`endif

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_DEFUSED = 3, M_EXPLODED = 4;

    typedef struct packed {
        logic          armed;
        logic          busy;
        logic          defused;
        logic          exploded;
        logic [TW-1:0] tl;
        logic [RW-1:0] tr;
    } snap_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    arm = 1'b0;
    logic                    tick_1hz = 1'b0;
    logic                    digit_valid = 1'b0;
    logic [3:0]              digit = '0;
    logic [4*CODE_LEN-1:0]   secret = 16'h4321;
    logic                    armed, busy, defused, exploded;
    logic [TW-1:0]           time_left;
    logic [RW-1:0]           tries_left;

    int    total = 0;
    int    bad = 0;
    int    mon_cyc = 0;
    snap_t exp_q[$];

    // reference model: session-level view of the bomb
    int mode = M_IDLE;
    int t = 0;
    int tr = 0;
    int chk = 0;
    bit ok = 0;
    int ent[$];

    controlador_desarme #(
        .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES),
        .START_TIME(START_TIME), .PENALTY(PENALTY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .tick_1hz(tick_1hz),
        .digit_valid(digit_valid), .digit(digit), .secret(secret),
        .armed(armed), .busy(busy), .defused(defused), .exploded(exploded),
        .time_left(time_left), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    function automatic bit code_matches();
        for (int k = 0; k < CODE_LEN; k++) begin
            if (ent[k] != int'(secret[4*k +: 4])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void burn(input int sub);
        t = (t > sub) ? t - sub : 0;
        if (t == 0) mode = M_EXPLODED;
    endfunction

    function automatic void model_step(input bit r, input bit a, input bit tk,
                                       input bit v, input logic [3:0] d);
        if (!r) begin
            mode = M_IDLE; t = 0; tr = 0; chk = 0; ent.delete();
            return;
        end
        case (mode)
            M_ENTRY: begin
                if (v) begin
                    ent.push_back(int'(d));
                    if (ent.size() == CODE_LEN) begin
                        ok = code_matches();
                        ent.delete();
                        chk = CODE_LEN;
                        mode = M_CHECK;
                    end
                end
                burn(int'(tk));
            end
            M_CHECK: begin
                int pen;
                pen = 0;
                chk--;
                if (chk == 0) begin
                    if (ok) mode = M_DEFUSED;
                    else begin
                        tr--;
                        pen = PEN;
                        mode = (tr == 0) ? M_EXPLODED : M_ENTRY;
                    end
                end
                burn(int'(tk) + pen);
            end
            default: begin
                if (a) begin
                    mode = M_ENTRY; t = START_TIME; tr = MAX_TRIES; ent.delete();
                end
            end
        endcase
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.armed    = (mode == M_ENTRY) || (mode == M_CHECK);
        s.busy     = (mode == M_CHECK);
        s.defused  = (mode == M_DEFUSED);
        s.exploded = (mode == M_EXPLODED);
        s.tl       = TW'(t);
        s.tr       = RW'(tr);
        return s;
    endfunction

    task automatic cyc(input bit r, input bit a, input bit tk, input bit v, input logic [3:0] d);
        rst_n = r; arm = a; tick_1hz = tk; digit_valid = v; digit = d;
        @(posedge clk);
        #1;
        model_step(r, a, tk, v, d);
        exp_q.push_back(model_snap());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'h0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 4'h0);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, code[4*k +: 4]);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 4'h0);
        cyc(0, 1, 0, 0, 4'h0);
    endtask

    // monitor: compare every presented cycle against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                snap_t e, g;
                e = exp_q.pop_front();
                g = '{armed, busy, defused, exploded, time_left, tries_left};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got arm=%b busy=%b def=%b exp=%b time=%0d tries=%0d want arm=%b busy=%b def=%b exp=%b time=%0d tries=%0d",
                             mon_cyc, g.armed, g.busy, g.defused, g.exploded, g.tl, g.tr,
                             e.armed, e.busy, e.defused, e.exploded, e.tl, e.tr);
                end
            end
            mon_cyc++;
        end
    end

    initial begin
        // correct code, back-to-back digits (secret digits 1,2,3,4 -> packed 16'h4321)
        secret = 16'h4321;
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        enter(16'h4321);
        idle(6);

        // three wrong attempts (1,2,3,5)
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        for (int a = 0; a < 3; a++) begin
            enter(16'h5321);
            idle(6);
        end

        // pure countdown expiry
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        ticks(START_TIME);
        idle(3);

        // digits during CHECK are ignored
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        enter(16'h5321);
        for (int i = 0; i < CODE_LEN; i++) cyc(1, 0, 0, 1, 4'($urandom));
        enter(16'h4321);
        idle(6);

        // expiry on the final CHECK edge of a correct code
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        ticks(START_TIME - 1);
        enter(16'h4321);
        idle(CODE_LEN - 1);
        cyc(1, 0, 1, 0, 4'h0);
        idle(3);

        // reset after two digits, then re-arm and defuse; arm and reset together
        do_reset();
        cyc(1, 1, 0, 0, 4'h0);
        cyc(1, 0, 0, 1, 4'h1);
        cyc(1, 0, 0, 1, 4'h2);
        cyc(0, 1, 0, 0, 4'h0);
        idle(2);
        cyc(1, 1, 0, 0, 4'h0);
        enter(16'h4321);
        idle(6);

        // randomized sessions
        for (int i = 0; i < 4000; i++) begin
            bit r, a, tk, v;
            logic [3:0] d;
            r  = ($urandom % 400) != 0;
            a  = ($urandom % 25) == 0;
            tk = ($urandom % 6) == 0;
            v  = ($urandom % 3) == 0;
            if (($urandom % 4) != 0 && ent.size() < CODE_LEN)
                d = secret[4*ent.size() +: 4];
            else
                d = 4'($urandom);
            if (!r) secret = 16'($urandom);
            cyc(r, a, tk, v, d);
        end

        cyc(1, 0, 0, 0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controlador_desarme.md
# controlador_desarme

Sequencing controller for the bomb's defuse keypad path. Collects CODE_LEN 4-bit digits, then drives the shared `comparador_4_bits` one digit per cycle against the armed secret. Tracks remaining attempts and a countdown driven by a 1 Hz tick. Declares the bomb defused or exploded.

## Interface
- CODE_LEN, 4: digits per code attempt (≥1).
- MAX_TRIES, 3: wrong attempts allowed before explosion (≥1).
- START_TIME, 60: countdown seconds loaded on arm (≥1).
- PENALTY, 10: seconds removed per wrong attempt (PENALTY_EN only).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- arm  in  1  one-cycle pulse; starts a session.
- tick_1hz  in  1  one-cycle pulse per second.
- digit_valid  in  1  keypad digit strobe.
- digit  in  4  keypad digit value.
- secret  in  4*CODE_LEN  code; digit k at bits [4k+3:4k], k=0 entered first; stable while armed.
- armed  out  1  high in ENTRY or CHECK.
- busy  out  1  high in CHECK; digits ignored.
- defused  out  1  high in DEFUSED.
- exploded  out  1  high in EXPLODED.
- time_left  out  $clog2(START_TIME+1)  seconds remaining.
- tries_left  out  $clog2(MAX_TRIES+1)  attempts remaining.

## Operation
- Reset (rst_n=0 at edge): state IDLE; all outputs 0; digit buffer, index and mismatch flag cleared.
- IDLE: tick/digits ignored. arm → ENTRY, time_left=START_TIME, tries_left=MAX_TRIES, idx=0.
- ENTRY: digit_valid stores digit in buf[idx] and increments idx. When the stored digit is digit CODE_LEN-1 → CHECK, idx=0, mismatch=0.
- CHECK: exactly CODE_LEN cycles. Cycle k drives the comparator with enable=1, q1=buf[k], q2=secret[k]; s=0 sets mismatch. Comparator enable=0 outside CHECK. digit_valid dropped.
- End of CHECK, no mismatch → DEFUSED.
- End of CHECK, mismatch → tries_left−1. If tries_left reaches 0 → EXPLODED; else → ENTRY with idx=0.
- tick_1hz in ENTRY/CHECK decrements time_left. Reaching 0 → EXPLODED from either state.
- DEFUSED/EXPLODED: terminal; time_left/tries_left frozen. arm re-arms as from IDLE. arm in ENTRY/CHECK ignored.
- Exactly one of armed/defused/exploded is high outside IDLE.

## Timing
- Digit accepted on the edge where digit_valid=1; one digit per cycle, back-to-back allowed.
- Last digit at edge N: CHECK cycles between edges N+1..N+CODE_LEN. Outcome state/outputs valid after edge N+CODE_LEN.
- Outputs are registered; no combinational input→output paths.
- Expiry has priority: tick driving time_left to 0 on the final CHECK edge → EXPLODED even on a correct code.
- Wrong final attempt and expiry on the same edge → EXPLODED; tries_left still decremented.
- rst_n low mid-CHECK or mid-ENTRY → IDLE at that edge; partial code discarded.
- arm and rst_n=0 on the same edge: reset wins.

## Configuration
- TIME_PENALTY_EN defined: each wrong attempt also subtracts PENALTY from time_left, saturating at 0. Reaching 0 → EXPLODED.
- Tick and penalty on the same edge subtract 1+PENALTY, saturating.
- Undefined: wrong attempts affect only tries_left; the PENALTY parameter is unused.

## Structure
- Package desarme_pkg:
  - DIGIT_W=4.
  - state enum: IDLE, ENTRY, CHECK, DEFUSED, EXPLODED.
  - helper function for secret digit slicing.
- One sub-module instance: `comparador_4_bits`, fed from the CHECK-cycle digit mux.
- Digit buffer, idx counter, countdown and tries counters live in controlador_desarme.

## Test plan
- Reset, arm, enter secret 4'h1,2,3,4 on consecutive cycles: CHECK for 4 cycles, then defused=1, tries_left=3, time_left=60.
- Secret 1234, enter 1235 three times: tries_left 2 → 1 → 0, then exploded=1 after the third CHECK. With TIME_PENALTY_EN, time_left drops 60 → 50 → 40 before explosion.
- Arm, send 60 ticks with no digits: time_left reaches 0 and exploded=1 on the 60th tick edge.
- digit_valid pulses during CHECK: ignored; buffer unchanged; next attempt starts at idx=0.
- Correct code with a tick driving time_left 1 → 0 on the final CHECK edge: exploded=1, defused=0.
- rst_n=0 after 2 digits: IDLE, all outputs 0. Re-arm and enter the correct code: defused=1.
